// File: rtl/sea_pkg.sv
// Shared SEA definitions: word width, mode encoding, FSM states, S-box and rotations.
package sea_pkg;

    localparam int unsigned SEA_W = 48;

    typedef logic [SEA_W-1:0] sea_word_t;

    localparam logic SEA_ENC = 1'b0;
    localparam logic SEA_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sea_state_e;

    function automatic logic [2:0] sea_sbox(input logic [2:0] x);
        logic [2:0] y;
        case (x)
            3'd0:    y = 3'd0;
            3'd1:    y = 3'd5;
            3'd2:    y = 3'd6;
            3'd3:    y = 3'd7;
            3'd4:    y = 3'd4;
            3'd5:    y = 3'd3;
            3'd6:    y = 3'd1;
            default: y = 3'd2;
        endcase
        return y;
    endfunction

    function automatic sea_word_t sea_rotl(input sea_word_t x, input int unsigned n);
        int unsigned s;
        s = n % SEA_W;
        if (s == 0) return x;
        return (x << s) | (x >> (SEA_W - s));
    endfunction

    function automatic sea_word_t sea_rotr(input sea_word_t x, input int unsigned n);
        int unsigned s;
        s = n % SEA_W;
        if (s == 0) return x;
        return (x >> s) | (x << (SEA_W - s));
    endfunction

endpackage

// File: rtl/sea_iter_core_if.sv
// Valid/ready stream bundle between a block source/sink and the SEA engine.
interface sea_iter_core_if;
    import sea_pkg::*;

    logic      in_valid;
    logic      in_ready;
    logic      in_mode;
    sea_word_t in_l;
    sea_word_t in_r;
    sea_word_t in_key;
    logic      out_valid;
    logic      out_ready;
    sea_word_t out_l;
    sea_word_t out_r;
    logic      busy;

    modport master (
        output in_valid, in_mode, in_l, in_r, in_key, out_ready,
        input  in_ready, out_valid, out_l, out_r, busy
    );

    modport slave (
        input  in_valid, in_mode, in_l, in_r, in_key, out_ready,
        output in_ready, out_valid, out_l, out_r, busy
    );

endinterface

// File: rtl/sea_round.sv
// One combinational SEA Feistel round; the 16 S-boxes are shared by both directions.
module sea_round
    import sea_pkg::*;
(
    input  logic      mode,
    input  sea_word_t l,
    input  sea_word_t r,
    input  sea_word_t k,
    output sea_word_t l_nxt,
    output sea_word_t r_nxt
);

    sea_word_t m;
    sea_word_t s;
    sea_word_t ro;

    // Decrypt keys the S-box layer from L, encrypt from R.
    assign m = ((mode == SEA_DEC) ? l : r) ^ k;

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        assign s[3*g +: 3] = sea_sbox(m[3*g +: 3]);
    end

    assign ro = sea_rotl(s, 1);

    always_comb begin
        if (mode == SEA_DEC) begin
            l_nxt = sea_rotl(ro ^ r, 8);
            r_nxt = l;
        end else begin
            l_nxt = r;
            r_nxt = ro ^ sea_rotr(l, 8);
        end
    end

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA engine: one Feistel round per clock, rotating round key, one block in flight.
module sea_iter_core
    import sea_pkg::*;
#(
    parameter int unsigned ROUNDS = 8,
    parameter int unsigned KROT   = 3
) (
    input logic           clk,
    input logic           rst_n,
    sea_iter_core_if.slave bus
);

    localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);
    // Decrypt starts from the last encrypt key and walks backwards.
    localparam int unsigned DEC_ROT  = (KROT * (ROUNDS - 1)) % SEA_W;

    sea_state_e state_q;
    sea_word_t  l_q;
    sea_word_t  r_q;
    sea_word_t  key_q;
    logic [5:0] cnt_q;
    logic       mode_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    sea_word_t  l_nxt;
    sea_word_t  r_nxt;

    sea_round u_round (
        .mode  (mode_q),
        .l     (l_q),
        .r     (r_q),
        .k     (key_q),
        .l_nxt (l_nxt),
        .r_nxt (r_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= SEA_ENC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        l_q        <= bus.in_l;
                        r_q        <= bus.in_r;
                        mode_q     <= bus.in_mode;
                        key_q      <= (bus.in_mode == SEA_DEC) ?
                                      sea_rotl(bus.in_key, DEC_ROT) : bus.in_key;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    l_q   <= l_nxt;
                    r_q   <= r_nxt;
                    key_q <= (mode_q == SEA_DEC) ? sea_rotr(key_q, KROT) : sea_rotl(key_q, KROT);
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_RND) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_l     = l_q;
    assign bus.out_r     = r_q;

endmodule

// File: tb/tb_sea_iter_core.sv
// Bench for sea_iter_core: ROUNDS=1 directed vectors, ROUNDS=8 model-checked traffic.
module tb_sea_iter_core;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [95:0] exp8;
    logic        exp8_vld;

    sea_iter_core_if b1 ();
    sea_iter_core_if b8 ();

    sea_iter_core #(.ROUNDS(1), .KROT(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    sea_iter_core #(.ROUNDS(8), .KROT(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the cipher definition.
    function automatic logic [47:0] t_rotl(input logic [47:0] x, input int n);
        logic [95:0] d;
        d = {x, x} << (n % 48);
        return d[95:48];
    endfunction

    function automatic logic [47:0] t_rotr(input logic [47:0] x, input int n);
        logic [95:0] d;
        d = {x, x} >> (n % 48);
        return d[47:0];
    endfunction

    function automatic logic [47:0] t_sub(input logic [47:0] x);
        logic [47:0] y;
        logic [2:0]  v;
        for (int g = 0; g < 16; g++) begin
            v = x[3*g +: 3];
            case (v)
                3'd0: v = 3'd0; 3'd1: v = 3'd5; 3'd2: v = 3'd6; 3'd3: v = 3'd7;
                3'd4: v = 3'd4; 3'd5: v = 3'd3; 3'd6: v = 3'd1; default: v = 3'd2;
            endcase
            y[3*g +: 3] = v;
        end
        return y;
    endfunction

    function automatic logic [95:0] m_enc(input logic [95:0] p, input logic [47:0] k0,
                                          input int rounds, input int krot);
        logic [47:0] l, r, k, ro, nl;
        l = p[95:48];
        r = p[47:0];
        for (int i = 0; i < rounds; i++) begin
            k  = t_rotl(k0, (krot * i) % 48);
            ro = t_rotl(t_sub(r ^ k), 1);
            nl = r;
            r  = ro ^ t_rotr(l, 8);
            l  = nl;
        end
        return {l, r};
    endfunction

    task automatic run1(input logic mode, input logic [47:0] l, input logic [47:0] r,
                        input logic [47:0] k, output logic [95:0] got);
        int lat;
        b1.in_valid = 1'b1;
        b1.in_mode  = mode;
        b1.in_l     = l;
        b1.in_r     = r;
        b1.in_key   = k;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        lat = 0;
        while (!b1.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat1", 96'(lat), 96'd1);
        got = {b1.out_l, b1.out_r};
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.out_ready = 1'b0;
        chk("idle1_after_take", 96'({b1.in_ready, b1.out_valid}), 96'b10);
    endtask

    task automatic run8(input logic mode, input logic [47:0] l, input logic [47:0] r,
                        input logic [47:0] k, input logic [95:0] exp, input int hold,
                        output logic [95:0] got);
        int lat;
        exp8     = exp;
        exp8_vld = 1'b1;
        b8.in_valid = 1'b1;
        b8.in_mode  = mode;
        b8.in_l     = l;
        b8.in_r     = r;
        b8.in_key   = k;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat8", 96'(lat), 96'd8);
        got = {b8.out_l, b8.out_r};
        for (int h = 0; h < hold; h++) begin
            b8.in_valid = ~b8.in_valid;
            b8.in_mode  = 1'($urandom);
            b8.in_l     = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            b8.in_r     = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            b8.in_key   = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            @(posedge clk); #1;
            chk("bp_data_stable", {b8.out_l, b8.out_r}, got);
            chk("bp_flags", 96'({b8.in_ready, b8.out_valid, b8.busy}), 96'b011);
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        exp8_vld     = 1'b0;
        chk("idle8_after_take", 96'({b8.in_ready, b8.out_valid, b8.busy}), 96'b100);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            chk("bp_no_second_accept", 96'({b8.in_ready, b8.out_valid, b8.busy}), 96'b100);
        end
    endtask

    // Single compare process for the ROUNDS=8 engine.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_vs_ready", 96'(b8.busy), 96'(!b8.in_ready));
            if (b8.out_valid) begin
                chk("out8_expected", 96'(exp8_vld), 96'd1);
                if (exp8_vld) chk("out8_data", {b8.out_l, b8.out_r}, exp8);
            end
        end
    end

    initial begin
        logic [95:0] got, got2, p, c;
        logic [47:0] k;
        errors = 0;
        checks = 0;
        exp8_vld = 1'b0;
        exp8 = '0;
        {b1.in_valid, b1.in_mode, b1.in_l, b1.in_r, b1.in_key, b1.out_ready} = '0;
        {b8.in_valid, b8.in_mode, b8.in_l, b8.in_r, b8.in_key, b8.out_ready} = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the model with hand-derived values.
        chk("model_pin_enc_k", m_enc({48'h0, 48'h0}, 48'h1, 1, 3), {48'h0, 48'hA});
        chk("model_pin_enc_l", m_enc({48'h1, 48'h0}, 48'h0, 1, 3), {48'h0, 48'h0100_0000_0000});

        run1(1'b0, 48'h0, 48'h0, 48'h1, got);
        chk("r1_enc_key", got, {48'h0, 48'h0000_0000_000A});
        run1(1'b0, 48'h1, 48'h0, 48'h0, got);
        chk("r1_enc_left", got, {48'h0, 48'h0100_0000_0000});
        run1(1'b1, 48'h0, 48'h0000_0000_000A, 48'h1, got);
        chk("r1_dec", got, {48'h0, 48'h0});

        // Reset while the 8-round engine is mid-block.
        b8.in_valid = 1'b1;
        b8.in_mode  = 1'b0;
        b8.in_l     = 48'h0123_4567_89AB;
        b8.in_r     = 48'hCDEF_0123_4567;
        b8.in_key   = 48'h0F1E_2D3C_4B5A;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_flags", 96'({b8.in_ready, b8.out_valid, b8.busy}), 96'b100);
        chk("rst_data", {b8.out_l, b8.out_r}, 96'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        p = {48'h0123_4567_89AB, 48'hCDEF_0123_4567};
        k = 48'h0F1E_2D3C_4B5A;
        c = m_enc(p, k, 8, 3);
        run8(1'b0, p[95:48], p[47:0], k, c, 0, got);
        chk("r8_fixed_enc", got, c);
        run8(1'b1, got[95:48], got[47:0], k, p, 0, got2);
        chk("r8_fixed_dec", got2, p);

        for (int n = 0; n < 200; n++) begin
            p = {$urandom, $urandom, $urandom};
            k = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            c = m_enc(p, k, 8, 3);
            run8(1'b0, p[95:48], p[47:0], k, c, 0, got);
            run8(1'b1, got[95:48], got[47:0], k, p, 0, got2);
            chk("r8_roundtrip", got2, p);
        end

        p = {48'hFFFF_0000_FFFF, 48'h1234_5678_9ABC};
        k = 48'h8000_0000_0001;
        c = m_enc(p, k, 8, 3);
        run8(1'b0, p[95:48], p[47:0], k, c, 5, got);
        chk("r8_bp_enc", got, c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
